// File: rtl/alu_issue_seq.sv
// Issue sequencer for the registered ALU. It accepts one RV32I integer instruction,
// reads its operands from the register file, drives the ALU and writes the result back.
module alu_issue_seq #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            rf_ren,
    output logic [RA_W-1:0] rf_raddr1,
    output logic [RA_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_en,
    output logic [RA_W-1:0] wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            illegal
);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SRL    = 4'd3;
    localparam logic [3:0] OP_SRA    = 4'd4;
    localparam logic [3:0] OP_SLT    = 4'd5;
    localparam logic [3:0] OP_SLTU   = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;
    localparam logic [3:0] OP_PASS_B = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] BSEL_RS2 = 2'd0;
    localparam logic [1:0] BSEL_IMM = 2'd1;
    localparam logic [1:0] BSEL_LUI = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_instr;
    logic [3:0]  r_op;
    logic        r_legal;
    logic [1:0]  r_bsel;

    logic        w_accept;
    logic [3:0]  w_dec_op;
    logic        w_dec_legal;
    logic [1:0]  w_dec_bsel;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_funct7 = r_instr[31:25];
    assign w_imm_i  = XLEN'($signed(r_instr[31:20]));
    assign w_imm_u  = XLEN'($signed({r_instr[31:12], 12'b0}));
    assign w_accept = (r_state == S_IDLE) && instr_valid && !rst;

    // OP and OP-IMM share the funct3 map; funct7 (imm[11:5] for OP-IMM) only
    // matters for OP in general and for the OP-IMM shifts.
    always_comb begin
        w_dec_op    = OP_ADD;
        w_dec_legal = 1'b0;
        w_dec_bsel  = BSEL_RS2;
        if (w_opcode == OPC_OP || w_opcode == OPC_OP_IMM) begin
            w_dec_bsel = (w_opcode == OPC_OP) ? BSEL_RS2 : BSEL_IMM;
            case (w_funct3)
                3'b000: begin
                    if (w_opcode == OPC_OP_IMM || w_funct7 == F7_ZERO) begin
                        w_dec_op    = OP_ADD;
                        w_dec_legal = 1'b1;
                    end else if (w_funct7 == F7_ALT) begin
                        w_dec_op    = OP_SUB;
                        w_dec_legal = 1'b1;
                    end
                end
                3'b001: begin
                    w_dec_op    = OP_SLL;
                    w_dec_legal = (w_funct7 == F7_ZERO);
                end
                3'b101: begin
                    if (w_funct7 == F7_ZERO) begin
                        w_dec_op    = OP_SRL;
                        w_dec_legal = 1'b1;
                    end else if (w_funct7 == F7_ALT) begin
                        w_dec_op    = OP_SRA;
                        w_dec_legal = 1'b1;
                    end
                end
                default: begin
                    case (w_funct3)
                        3'b010:  w_dec_op = OP_SLT;
                        3'b011:  w_dec_op = OP_SLTU;
                        3'b100:  w_dec_op = OP_XOR;
                        3'b110:  w_dec_op = OP_OR;
                        default: w_dec_op = OP_AND;
                    endcase
                    w_dec_legal = (w_opcode == OPC_OP_IMM) || (w_funct7 == F7_ZERO);
                end
            endcase
        end else if (w_opcode == OPC_LUI) begin
            w_dec_op    = OP_PASS_B;
            w_dec_legal = 1'b1;
            w_dec_bsel  = BSEL_LUI;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_READ;
            S_READ:  w_state_next = w_dec_legal ? S_EXEC : S_WB;
            S_EXEC:  w_state_next = S_WB;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_op    <= OP_ADD;
            r_legal <= 1'b0;
            r_bsel  <= BSEL_RS2;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_instr <= instr;
            end
            if (r_state == S_READ) begin
                r_op    <= w_dec_op;
                r_legal <= w_dec_legal;
                r_bsel  <= w_dec_bsel;
            end
        end
    end

    // Outputs are gated by rst so an aborted instruction never shows done or wb_en.
    always_comb begin
        instr_ready = 1'b0;
        rf_ren      = 1'b0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        alu_op      = OP_ADD;
        alu_a       = '0;
        alu_b       = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: instr_ready = 1'b1;
                S_READ: begin
                    rf_ren    = 1'b1;
                    rf_raddr1 = RA_W'(r_instr[19:15]);
                    rf_raddr2 = RA_W'(r_instr[24:20]);
                end
                S_EXEC: begin
                    alu_op = r_op;
                    alu_a  = (r_bsel == BSEL_LUI) ? '0 : rf_rdata1;
                    case (r_bsel)
                        BSEL_IMM: alu_b = w_imm_i;
                        BSEL_LUI: alu_b = w_imm_u;
                        default:  alu_b = rf_rdata2;
                    endcase
                end
                default: begin
                    done    = 1'b1;
                    illegal = !r_legal;
                    wb_en   = r_legal && (r_instr[11:7] != 5'd0);
                    wb_addr = RA_W'(r_instr[11:7]);
                    wb_data = alu_result;
                end
            endcase
        end
    end

endmodule
